tmec_decode_control: RTL and testbench
======================================

Name: tmec_decode_control

Overview:
- Sequencer for the serial inversion-based Berlekamp key-equation datapath (the serial TMEC decoder core).
- Accepts a "syndromes valid" start and drives that core's strobes for T iterations: synpe, snce, bsel, caLast, cbBeg, msmpe, cce, dringPe, c0first.
- Tracks the error-locator degree L from the core's drnzero feedback and reports completion, degree and an uncorrectable flag to the downstream Chien-search stage.

Parameters:
- M, 4, GF(2^M) field width; per-phase bit-serial cycle count.
- T, 3, correctable errors; number of Berlekamp iterations.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  syndromes valid; sampled only in IDLE.
- drnzero  input  1  discrepancy-nonzero feedback from the core.
- ready  output  1  high in IDLE only.
- synpe  output  1  syndrome/C1 parallel-load strobe.
- cbBeg  output  1  clear C2..CT / begin strobe.
- snce  output  1  syndrome ring shift enable.
- msmpe  output  1  standard-multiplier start.
- caLast  output  1  last cycle of discrepancy phase.
- dringPe  output  1  dual-ring / mixed-multiplier start.
- cce  output  1  C-polynomial shift enable.
- bsel  output  1  B-register update select (Berlekamp length change).
- c0first  output  1  use C0 term (iteration 0 only).
- done  output  1  one-cycle completion pulse.
- err_count  output  ceil(log2(T+1))+1  final L, held until next start.
- uncorrectable  output  1  L > T at completion, held with err_count.

Behaviour:
- Reset (reset_n=0 at an edge, checked before any other condition): state=IDLE, every strobe output 0, done=0, bsel=0, err_count=0, uncorrectable=0, ready=1. Reset mid-run aborts immediately; no done is produced.
- States: IDLE -> LOAD -> INIT -> ITER_A -> ITER_B -> (ITER_A | FIN) -> IDLE.
- IDLE: ready=1. start=1 -> LOAD. start outside IDLE is ignored, with no queuing.
- LOAD (1 cycle): synpe=1. L cleared to 0, iteration index i=0.
- INIT (1 cycle): cbBeg=1.
- ITER_A (M cycles, bit counter c=0..M-1, discrepancy phase):
  - snce=1 on all M cycles.
  - msmpe=1 at c=0.
  - caLast=1 at c=M-1.
  - c0first=1 on all cycles of iteration i=0.
  - At c=M-1, drnzero is sampled and the Berlekamp decision is made with r=2i+1:
    - if drnzero=1 and 2L <= 2i: bsel<=1 and L<=r-L.
    - otherwise: bsel<=0 and L unchanged.
  - bsel is registered, valid from the first ITER_B cycle, and held through ITER_B.
- ITER_B (M cycles, c=0..M-1, update phase):
  - cce=1 on all M cycles.
  - dringPe=1 at c=0.
  - At c=M-1: if i=T-1 -> FIN, else i<=i+1 and -> ITER_A.
- FIN (1 cycle): done=1; err_count<=L; uncorrectable<=(L>T); -> IDLE. bsel cleared on FIN exit.
- Strobe exclusivity: synpe, cbBeg, caLast and dringPe are never high in the same cycle. cce and snce are never both high.
- Latency: if start is accepted at edge e0, then synpe is high in cycle 1, cbBeg in cycle 2, iteration i phase A spans cycles 3+2Mi .. 2+2Mi+M, and done is high in cycle 3+2MT.
- Back-to-back: start high during the done cycle is ignored. A new run starts from IDLE, i.e. no earlier than the cycle after done.
- Counters wrap explicitly:
  - c resets to 0 on every phase change.
  - i saturates at T-1.
  - L is wide enough for 2T with no overflow.

Test Plan:
- M=4,T=3, reset then start pulse at cycle 0, drnzero=0 throughout -> synpe@1, cbBeg@2, msmpe@3,11,19, caLast@6,14,22, dringPe@7,15,23, done@27, err_count=0, uncorrectable=0, bsel never 1.
- Same run, drnzero=1 only at caLast of i=0 -> bsel=1 during cycles 7-10 and 0 afterwards, err_count=1.
- drnzero=1 at every caLast (T=3) -> L goes 1, 2, 3 (bsel=1 in all three B phases), err_count=3, uncorrectable=0.
- start held high continuously -> runs repeat with successive synpe pulses 28 cycles apart (next at cycle 29). ready=0 from cycle 1 to 27, and start during busy has no effect.
- reset_n=0 at cycle 12 mid-run -> all strobes 0 from cycle 13, ready=1, no done, err_count keeps its reset value 0. A subsequent start runs a normal full sequence.
- Parameter sweep M=8,T=5, drnzero random -> done at cycle 83. A reference Berlekamp model on the sampled drnzero sequence matches err_count, and the strobe-exclusivity assertions never fire.

Source files
------------

// File: rtl/tmec_decode_control.sv
// Sequencer for the serial inversion-based Berlekamp key-equation core.
// Runs T two-phase iterations of M bit-serial cycles and tracks the locator degree L.
module tmec_decode_control #(
  parameter int M = 4,
  parameter int T = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   drnzero,
  output logic                   ready,
  output logic                   synpe,
  output logic                   cbBeg,
  output logic                   snce,
  output logic                   msmpe,
  output logic                   caLast,
  output logic                   dringPe,
  output logic                   cce,
  output logic                   bsel,
  output logic                   c0first,
  output logic                   done,
  output logic [$clog2(T+1):0]   err_count,
  output logic                   uncorrectable,
  output logic [2:0]             o_dbg_state
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = (T > 1) ? $clog2(T) : 1;
  localparam int LW = $clog2(T + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_INIT   = 3'd2,
    S_ITER_A = 3'd3,
    S_ITER_B = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_c;
  logic [IW-1:0]   r_i;
  logic [LW-1:0]   r_l;
  logic [LW-1:0]   r_err;
  logic            r_bsel;
  logic            r_unc;

  logic            w_c_last;
  logic            w_i_last;
  logic [LW-1:0]   w_i_ext;
  logic [LW-1:0]   w_r;
  logic            w_upd;

  assign w_c_last = (r_c == CW'(M - 1));
  assign w_i_last = (r_i == IW'(T - 1));
  assign w_i_ext  = LW'(r_i);
  // r = 2i+1; a length change happens when the discrepancy is nonzero and 2L <= 2i
  assign w_r      = {w_i_ext[LW-2:0], 1'b1};
  assign w_upd    = drnzero && (r_l <= w_i_ext);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_i     <= '0;
      r_l     <= '0;
      r_err   <= '0;
      r_bsel  <= 1'b0;
      r_unc   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_LOAD: begin
          r_l <= '0;
          r_i <= '0;
          r_c <= '0;
        end
        S_ITER_A: begin
          if (w_c_last) begin
            r_c    <= '0;
            r_bsel <= w_upd;
            if (w_upd) r_l <= w_r - r_l;
          end else begin
            r_c <= r_c + 1'b1;
          end
        end
        S_ITER_B: begin
          // bsel only qualifies the update phase it was decided for
          if (w_c_last) begin
            r_c    <= '0;
            r_bsel <= 1'b0;
            if (!w_i_last) r_i <= r_i + 1'b1;
          end else begin
            r_c <= r_c + 1'b1;
          end
        end
        S_FIN: begin
          r_err  <= r_l;
          r_unc  <= (r_l > LW'(T));
          r_bsel <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    ready   = 1'b0;
    synpe   = 1'b0;
    cbBeg   = 1'b0;
    snce    = 1'b0;
    msmpe   = 1'b0;
    caLast  = 1'b0;
    dringPe = 1'b0;
    cce     = 1'b0;
    c0first = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        synpe  = 1'b1;
        w_next = S_INIT;
      end
      S_INIT: begin
        cbBeg  = 1'b1;
        w_next = S_ITER_A;
      end
      S_ITER_A: begin
        snce    = 1'b1;
        msmpe   = (r_c == '0);
        caLast  = w_c_last;
        c0first = (r_i == '0);
        if (w_c_last) w_next = S_ITER_B;
      end
      S_ITER_B: begin
        cce     = 1'b1;
        dringPe = (r_c == '0);
        if (w_c_last) w_next = w_i_last ? S_FIN : S_ITER_A;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bsel          = r_bsel;
  assign err_count     = r_err;
  assign uncorrectable = r_unc;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_tmec_decode_control.sv
// Bench for tmec_decode_control: two instances (M=4,T=3 and M=8,T=5) share stimulus and
// are checked every cycle against a cycle-index schedule model with a Berlekamp degree tracker.
module tb_tmec_decode_control;

  localparam int M1 = 4;
  localparam int T1 = 3;
  localparam int M2 = 8;
  localparam int T2 = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic drnzero = 1'b0;

  logic a_ready, a_synpe, a_cbBeg, a_snce, a_msmpe, a_caLast, a_dringPe, a_cce;
  logic a_bsel, a_c0first, a_done, a_unc;
  logic [$clog2(T1+1):0] a_err;
  logic [2:0] a_st;
  logic b_ready, b_synpe, b_cbBeg, b_snce, b_msmpe, b_caLast, b_dringPe, b_cce;
  logic b_bsel, b_c0first, b_done, b_unc;
  logic [$clog2(T2+1):0] b_err;
  logic [2:0] b_st;

  logic [10:0] a_vec, b_vec;
  assign a_vec = {a_ready, a_synpe, a_cbBeg, a_snce, a_msmpe, a_caLast, a_dringPe, a_cce,
                  a_bsel, a_c0first, a_done};
  assign b_vec = {b_ready, b_synpe, b_cbBeg, b_snce, b_msmpe, b_caLast, b_dringPe, b_cce,
                  b_bsel, b_c0first, b_done};

  int total = 0;
  int bad = 0;

  // model state per instance
  bit run [2];
  int k   [2];
  int lm  [2];
  bit bm  [2];
  int em  [2];
  bit um  [2];

  tmec_decode_control #(.M(M1), .T(T1)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start), .drnzero(drnzero),
    .ready(a_ready), .synpe(a_synpe), .cbBeg(a_cbBeg), .snce(a_snce), .msmpe(a_msmpe),
    .caLast(a_caLast), .dringPe(a_dringPe), .cce(a_cce), .bsel(a_bsel),
    .c0first(a_c0first), .done(a_done), .err_count(a_err), .uncorrectable(a_unc),
    .o_dbg_state(a_st)
  );

  tmec_decode_control #(.M(M2), .T(T2)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start), .drnzero(drnzero),
    .ready(b_ready), .synpe(b_synpe), .cbBeg(b_cbBeg), .snce(b_snce), .msmpe(b_msmpe),
    .caLast(b_caLast), .dringPe(b_dringPe), .cce(b_cce), .bsel(b_bsel),
    .c0first(b_c0first), .done(b_done), .err_count(b_err), .uncorrectable(b_unc),
    .o_dbg_state(b_st)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Expected {ready,synpe,cbBeg,snce,msmpe,caLast,dringPe,cce,bsel,c0first,done}
  function automatic logic [10:0] exp_vec(input int m, input int t, input bit r,
                                          input int kk, input bit b);
    logic rdy, sp, cb, sn, ms, ca, dp, cc, bs, c0, dn;
    int j, i, p;
    {rdy, sp, cb, sn, ms, ca, dp, cc, bs, c0, dn} = '0;
    if (!r) begin
      rdy = 1'b1;
    end else begin
      sp = (kk == 1);
      cb = (kk == 2);
      dn = (kk == 3 + 2 * m * t);
      if (kk >= 3 && kk <= 2 + 2 * m * t) begin
        j = kk - 3;
        i = j / (2 * m);
        p = j % (2 * m);
        if (p < m) begin
          sn = 1'b1;
          ms = (p == 0);
          ca = (p == m - 1);
          c0 = (i == 0);
        end else begin
          cc = 1'b1;
          dp = (p == m);
          bs = b;
        end
      end
    end
    return {rdy, sp, cb, sn, ms, ca, dp, cc, bs, c0, dn};
  endfunction

  task automatic check_inst(input int x, input logic [10:0] v, input int e, input logic u);
    int m, t;
    logic [10:0] ev;
    m = (x == 0) ? M1 : M2;
    t = (x == 0) ? T1 : T2;
    ev = exp_vec(m, t, run[x], k[x], bm[x]);
    total++;
    if (v !== ev) begin
      bad++;
      $display("FAIL strobes inst%0d k=%0d got=%b exp=%b at %0t", x, k[x], v, ev, $time);
    end
    cmp($sformatf("err_count inst%0d", x), e, em[x]);
    cmp($sformatf("uncorrectable inst%0d", x), int'(u), int'(um[x]));
    total++;
    if (($countones({v[9], v[8], v[5], v[4]}) > 1) || (v[7] && v[3])) begin
      bad++;
      $display("FAIL exclusivity inst%0d got=%b exp=one-hot at %0t", x, v, $time);
    end
  endtask

  task automatic advance(input int x);
    int m, t, last, j, i, p;
    m = (x == 0) ? M1 : M2;
    t = (x == 0) ? T1 : T2;
    last = 3 + 2 * m * t;
    if (!reset_n) begin
      run[x] = 0; lm[x] = 0; bm[x] = 0; em[x] = 0; um[x] = 0;
    end else if (!run[x]) begin
      if (start) begin
        run[x] = 1; k[x] = 1; lm[x] = 0;
      end
    end else begin
      if (k[x] >= 3 && k[x] < last) begin
        j = k[x] - 3;
        i = j / (2 * m);
        p = j % (2 * m);
        if (p == m - 1) begin
          if (drnzero && (2 * lm[x] <= 2 * i)) begin
            bm[x] = 1;
            lm[x] = 2 * i + 1 - lm[x];
          end else begin
            bm[x] = 0;
          end
        end
      end
      if (k[x] == last) begin
        em[x] = lm[x];
        um[x] = (lm[x] > t);
        run[x] = 0;
      end else begin
        k[x] = k[x] + 1;
      end
    end
  endtask

  // Inputs change 2 time units after posedge, so they are stable here and at the next edge
  always @(negedge clk) begin
    check_inst(0, a_vec, int'(a_err), a_unc);
    check_inst(1, b_vec, int'(b_err), b_unc);
    advance(0);
    advance(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_dir(input logic [7:0] pat, input int exp_err, input logic exp_unc);
    int done_at;
    logic bs8, bs12, sp1;
    done_at = -1;
    bs8 = 1'b0; bs12 = 1'b0; sp1 = 1'b0;
    tick();
    start = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      start = 1'b0;
      drnzero = (n >= 3 && n <= 26) ? pat[(n - 3) / 8] : 1'b0;
      @(negedge clk);
      if (a_done && done_at < 0) done_at = n;
      if (n == 1) sp1 = a_synpe;
      if (n == 8) bs8 = a_bsel;
      if (n == 12) bs12 = a_bsel;
    end
    cmp("synpe_at_1", int'(sp1), 1);
    cmp("done_cycle", done_at, 27);
    cmp("err_count_lit", int'(a_err), exp_err);
    cmp("unc_lit", int'(a_unc), int'(exp_unc));
    cmp("bsel_at_8", int'(bs8), int'(pat[0]));
    cmp("bsel_at_12", int'(bs12), 0);
  endtask

  initial begin
    int first, second, dn_cnt, d2;
    logic r27, r28, rr;
    logic [9:0] rs;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    cmp("reset_ready", int'(a_ready), 1);
    cmp("reset_err", int'(a_err), 0);
    cmp("reset_done", int'(a_done), 0);

    run_dir(8'h00, 0, 1'b0);
    run_dir(8'h01, 1, 1'b0);
    run_dir(8'h07, 3, 1'b0);
    run_dir(8'h04, 5, 1'b1);

    // start held high continuously
    first = -1; second = -1; r27 = 1'b1; r28 = 1'b0;
    tick();
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      drnzero = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (a_synpe) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      if (n == 27) r27 = a_ready;
      if (n == 28) r28 = a_ready;
    end
    tick();
    start = 1'b0;
    cmp("hold_first_synpe", first, 1);
    cmp("hold_second_synpe", second, 29);
    cmp("hold_ready_27", int'(r27), 0);
    cmp("hold_ready_28", int'(r28), 1);
    repeat (40) tick();

    // reset mid-run
    dn_cnt = 0; rr = 1'b0; rs = '1;
    tick();
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      start = 1'b0;
      reset_n = (n == 12) ? 1'b0 : 1'b1;
      drnzero = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (n == 13) begin
        rr = a_ready;
        rs = a_vec[9:0];
      end
      if (a_done) dn_cnt++;
    end
    cmp("midreset_ready", int'(rr), 1);
    cmp("midreset_strobes", int'(rs), 0);
    cmp("midreset_no_done", dn_cnt, 0);
    cmp("midreset_err", int'(a_err), 0);
    run_dir(8'h03, 2, 1'b0);

    // M=8,T=5 instance timing with random discrepancy feedback
    repeat (100) tick();
    d2 = -1;
    tick();
    start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      start = 1'b0;
      drnzero = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b_done && d2 < 0) d2 = n;
    end
    cmp("sweep_done_cycle", d2, 83);

    // random traffic
    repeat (1500) begin
      tick();
      start = ($urandom_range(0, 7) == 0);
      drnzero = 1'($urandom_range(0, 1));
      reset_n = ($urandom_range(0, 399) != 0);
    end
    tick();
    reset_n = 1'b1;
    start = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
